wrr_pkt_scheduler: RTL and testbench

- Packet-granular weighted round-robin scheduler.
- Shares one AXI4-Stream output among NUM_QUEUES AXI4-Stream requesters, typically the per-port RX paths in front of the capture datapath.
- No internal buffering: it muxes the granted requester straight through and holds the grant until tlast.
- Per-queue weights (packets per turn) come from the register block.

---
 rtl/wrr_pkt_scheduler.sv | 177 +++++++++++++++++
 tb/tb_wrr_pkt_scheduler.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wrr_pkt_scheduler.sv
// Packet-granular weighted round-robin AXI4-Stream scheduler, no buffering.
// Define WRR_PKT_CNT_EN to enable the per-queue saturating packet counters.
module wrr_pkt_scheduler #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_QUEUES         = 5,
  parameter int WEIGHT_WIDTH       = 4
) (
  input  logic axi_aclk,
  input  logic axi_resetn,

  input  logic [NUM_QUEUES*C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [NUM_QUEUES*C_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic [NUM_QUEUES*C_AXIS_TUSER_WIDTH-1:0]  s_axis_tuser,
  input  logic [NUM_QUEUES-1:0]                     s_axis_tvalid,
  input  logic [NUM_QUEUES-1:0]                     s_axis_tlast,
  output logic [NUM_QUEUES-1:0]                     s_axis_tready,

  output logic [C_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]  m_axis_tuser,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,

  input  logic [NUM_QUEUES*WEIGHT_WIDTH-1:0] weight,
  output logic [$clog2(NUM_QUEUES)-1:0]      grant_queue,
  output logic                               pkt_fwd,
  output logic [NUM_QUEUES*32-1:0]           pkt_cnt,
  input  logic                               pkt_cnt_clr
);

  localparam int DW = C_AXIS_DATA_WIDTH;
  localparam int SW = C_AXIS_DATA_WIDTH / 8;
  localparam int TW = C_AXIS_TUSER_WIDTH;
  localparam int WW = WEIGHT_WIDTH;
  localparam int QW = $clog2(NUM_QUEUES);

  typedef enum logic {
    IDLE,
    XFER
  } state_t;

  state_t state;
  state_t state_nx;

  logic [QW-1:0] cur_queue;
  logic [QW-1:0] cur_nx;
  logic [QW-1:0] pick;
  logic          found;
  logic [WW-1:0] credit;
  logic [WW-1:0] credit_nx;
  logic          pkt_fwd_nx;
  logic          eop;

  logic [NUM_QUEUES-1:0] elig;

  logic [DW-1:0] tdata_a  [NUM_QUEUES];
  logic [SW-1:0] tstrb_a  [NUM_QUEUES];
  logic [TW-1:0] tuser_a  [NUM_QUEUES];
  logic [WW-1:0] weight_a [NUM_QUEUES];

  for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_split
    assign tdata_a[g]  = s_axis_tdata[g*DW +: DW];
    assign tstrb_a[g]  = s_axis_tstrb[g*SW +: SW];
    assign tuser_a[g]  = s_axis_tuser[g*TW +: TW];
    assign weight_a[g] = weight[g*WW +: WW];
    assign elig[g]     = s_axis_tvalid[g]
                       & (weight[g*WW +: WW] != '0);
  end

  // Circular first-set search starting at cur_queue.
  always_comb begin : p_pick
    logic [QW:0] idx;
    pick  = cur_queue;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      idx = {1'b0, cur_queue} + (QW+1)'(i);
      if (idx >= (QW+1)'(NUM_QUEUES)) begin
        idx = idx - (QW+1)'(NUM_QUEUES);
      end
      if (!found && elig[idx[QW-1:0]]) begin
        pick  = idx[QW-1:0];
        found = 1'b1;
      end
    end
  end

  assign eop = (state == XFER)
             & s_axis_tvalid[cur_queue]
             & m_axis_tready
             & s_axis_tlast[cur_queue];

  always_comb begin
    state_nx   = state;
    cur_nx     = cur_queue;
    credit_nx  = credit;
    pkt_fwd_nx = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_nx = XFER;
          if (!(pick == cur_queue && credit != '0)) begin
            cur_nx    = pick;
            credit_nx = weight_a[pick];
          end
        end
      end
      XFER: begin
        if (eop) begin
          state_nx   = IDLE;
          pkt_fwd_nx = 1'b1;
          if (credit == WW'(1)) begin
            cur_nx = (cur_queue == QW'(NUM_QUEUES-1))
                   ? '0 : cur_queue + 1'b1;
            credit_nx = '0;
          end else begin
            credit_nx = credit - 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state     <= IDLE;
      cur_queue <= '0;
      credit    <= '0;
      pkt_fwd   <= 1'b0;
    end else begin
      state     <= state_nx;
      cur_queue <= cur_nx;
      credit    <= credit_nx;
      pkt_fwd   <= pkt_fwd_nx;
    end
  end

  assign grant_queue   = cur_queue;
  assign m_axis_tdata  = tdata_a[cur_queue];
  assign m_axis_tstrb  = tstrb_a[cur_queue];
  assign m_axis_tuser  = tuser_a[cur_queue];
  assign m_axis_tlast  = s_axis_tlast[cur_queue];
  assign m_axis_tvalid = (state == XFER)
                       & s_axis_tvalid[cur_queue];

  always_comb begin
    s_axis_tready = '0;
    if (state == XFER) begin
      s_axis_tready[cur_queue] = m_axis_tready;
    end
  end

`ifdef WRR_PKT_CNT_EN
  for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_cnt
    logic [31:0] cnt;
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
        cnt <= '0;
      end else if (pkt_cnt_clr) begin
        cnt <= '0;
      end else if (eop && cur_queue == QW'(g)
                   && cnt != 32'hFFFF_FFFF) begin
        cnt <= cnt + 32'd1;
      end
    end
    assign pkt_cnt[g*32 +: 32] = cnt;
  end
`else
  logic unused_clr;
  assign unused_clr = pkt_cnt_clr;
  assign pkt_cnt    = '0;
`endif

endmodule

// File: tb/tb_wrr_pkt_scheduler.sv
// Randomized bench for wrr_pkt_scheduler against a packet-level WRR model.
// Counter expectations follow WRR_PKT_CNT_EN when it is defined.
module tb_wrr_pkt_scheduler;

  localparam int N  = 5;
  localparam int DW = 256;
  localparam int SW = DW / 8;
  localparam int TW = 128;
  localparam int WW = 4;
  localparam int QW = $clog2(N);
  localparam int CW = 256;

  logic clk;
  logic rst_n;
  logic [N*DW-1:0] s_axis_tdata;
  logic [N*SW-1:0] s_axis_tstrb;
  logic [N*TW-1:0] s_axis_tuser;
  logic [N-1:0]    s_axis_tvalid;
  logic [N-1:0]    s_axis_tlast;
  logic [N-1:0]    s_axis_tready;
  logic [DW-1:0]   m_axis_tdata;
  logic [SW-1:0]   m_axis_tstrb;
  logic [TW-1:0]   m_axis_tuser;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic            m_axis_tlast;
  logic [N*WW-1:0] weight;
  logic [QW-1:0]   grant_queue;
  logic            pkt_fwd;
  logic [N*32-1:0] pkt_cnt;
  logic            pkt_cnt_clr;

  wrr_pkt_scheduler dut (
    .axi_aclk      (clk),
    .axi_resetn    (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tstrb  (s_axis_tstrb),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .weight        (weight),
    .grant_queue   (grant_queue),
    .pkt_fwd       (pkt_fwd),
    .pkt_cnt       (pkt_cnt),
    .pkt_cnt_clr   (pkt_cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;

  task automatic check(input string tag,
                       input logic [CW-1:0] obs,
                       input logic [CW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Source state, one packet stream per queue
  bit vld  [N];
  bit hold [N];
  int len  [N];
  int beat [N];
  int seq  [N];
  int left [N];
  int gap_at  [N];
  int gap_len [N];
  int gap_cnt [N];
  int wt [N];
  bit rnd_stall;
  bit rnd_len;
  int fix_len;
  int rdy_mode;
  bit clr_req;

  // Packet-level WRR model
  bit          m_busy;
  int          m_cur;
  int          m_rem;
  bit          m_fwd;
  logic [31:0] m_cnt [N];

  int cyc;
  int first_tr;
  int out_beats;
  int fwd_seen;
  int obs_starts [$];

  function automatic logic [DW-1:0] mk_data(int q, int s, int b);
    logic [DW-1:0] d;
    for (int w = 0; w < DW/32; w++) begin
      d[w*32 +: 32] = (32'(q) * 32'h0100_0193)
                    ^ (32'(s) * 32'h9E37_79B9)
                    ^ (32'(b) * 32'h85EB_CA6B)
                    ^ (32'(w) * 32'h27D4_EB2F);
    end
    return d;
  endfunction

  function automatic logic [SW-1:0] mk_strb(logic [DW-1:0] d);
    return d[SW-1:0] ^ d[2*SW-1:SW];
  endfunction

  function automatic logic [TW-1:0] mk_user(logic [DW-1:0] d);
    return ~d[DW-1 -: TW];
  endfunction

  function automatic int new_len();
    if (rnd_len) return $urandom_range(1, 5);
    return fix_len;
  endfunction

  task automatic clear_tb();
    for (int q = 0; q < N; q++) begin
      vld[q] = 0; hold[q] = 0;
      len[q] = fix_len; beat[q] = 0; seq[q] = 0;
      left[q] = 0; gap_at[q] = -1; gap_len[q] = 0;
      gap_cnt[q] = 0; m_cnt[q] = '0;
    end
    m_busy = 0; m_cur = 0; m_rem = 0; m_fwd = 0;
    out_beats = 0; fwd_seen = 0; clr_req = 0;
    obs_starts.delete();
  endtask

  task automatic drive();
    logic [DW-1:0] d;
    for (int q = 0; q < N; q++) begin
      if (left[q] == 0) vld[q] = 0;
      else if (hold[q]) vld[q] = 1;
      else if (gap_cnt[q] > 0) vld[q] = 0;
      else if (rnd_stall) vld[q] = ($urandom_range(0, 3) != 0);
      else vld[q] = 1;
      d = mk_data(q, seq[q], beat[q]);
      s_axis_tdata[q*DW +: DW] = d;
      s_axis_tstrb[q*SW +: SW] = mk_strb(d);
      s_axis_tuser[q*TW +: TW] = mk_user(d);
      s_axis_tlast[q]  = (beat[q] == len[q] - 1);
      s_axis_tvalid[q] = vld[q];
      weight[q*WW +: WW] = WW'(wt[q]);
    end
    case (rdy_mode)
      0: m_axis_tready = 1'b1;
      1: m_axis_tready = ~m_axis_tready;
      default: m_axis_tready = 1'($urandom_range(0, 1));
    endcase
    pkt_cnt_clr = clr_req;
  endtask

  task automatic cycle();
    logic [N-1:0]    exp_tr;
    logic            exp_tv;
    logic [DW-1:0]   d;
    logic [N*32-1:0] exp_cnt;
    int p;
    bit hs;
    bit last;
    exp_tr = '0;
    exp_tv = 1'b0;
    if (m_busy) begin
      exp_tr[m_cur] = m_axis_tready;
      exp_tv = vld[m_cur];
    end
    for (int q = 0; q < N; q++) exp_cnt[q*32 +: 32] = m_cnt[q];
    check("grant_queue", CW'(grant_queue), CW'(m_cur));
    check("pkt_fwd", CW'(pkt_fwd), CW'(m_fwd));
    check("s_tready", CW'(s_axis_tready), CW'(exp_tr));
    check("m_tvalid", CW'(m_axis_tvalid), CW'(exp_tv));
    check("pkt_cnt", CW'(pkt_cnt), CW'(exp_cnt));
    if (exp_tv) begin
      d = mk_data(m_cur, seq[m_cur], beat[m_cur]);
      check("m_tdata", CW'(m_axis_tdata), CW'(d));
      check("m_tstrb", CW'(m_axis_tstrb), CW'(mk_strb(d)));
      check("m_tuser", CW'(m_axis_tuser), CW'(mk_user(d)));
      check("m_tlast", CW'(m_axis_tlast),
            CW'(beat[m_cur] == len[m_cur] - 1));
    end

    if (first_tr < 0 && s_axis_tready != '0) first_tr = cyc;
    if (m_axis_tvalid && m_axis_tready) out_beats++;
    if (pkt_fwd) fwd_seen++;
    cyc++;

    m_fwd = 0;
    if (!m_busy) begin
      p = -1;
      for (int k = 0; k < N; k++) begin
        int q;
        q = (m_cur + k) % N;
        if (p < 0 && vld[q] && wt[q] != 0) p = q;
      end
      if (p >= 0) begin
        if (!(p == m_cur && m_rem > 0)) begin
          m_cur = p;
          m_rem = wt[p];
        end
        m_busy = 1;
      end
    end else if (vld[m_cur] && m_axis_tready
                 && beat[m_cur] == len[m_cur] - 1) begin
      m_busy = 0;
      m_fwd  = 1;
      if (m_cnt[m_cur] != 32'hFFFF_FFFF) m_cnt[m_cur]++;
      m_rem--;
      if (m_rem == 0) m_cur = (m_cur + 1) % N;
    end
`ifdef WRR_PKT_CNT_EN
    if (clr_req) begin
      for (int q = 0; q < N; q++) m_cnt[q] = '0;
    end
`else
    for (int q = 0; q < N; q++) m_cnt[q] = '0;
`endif

    for (int q = 0; q < N; q++) begin
      hs = vld[q] && s_axis_tready[q];
      hold[q] = vld[q] && !hs;
      if (gap_cnt[q] > 0) gap_cnt[q]--;
      if (hs) begin
        if (beat[q] == 0) obs_starts.push_back(q);
        if (beat[q] == gap_at[q]) gap_cnt[q] = gap_len[q];
        last = (beat[q] == len[q] - 1);
        if (last) begin
          beat[q] = 0;
          seq[q]++;
          if (left[q] > 0) left[q]--;
          len[q] = new_len();
        end else begin
          beat[q]++;
        end
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      drive();
      @(negedge clk);
      cycle();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    s_axis_tvalid = '1;
    s_axis_tlast  = '1;
    m_axis_tready = 1'b1;
    pkt_cnt_clr   = 1'b0;
    clear_tb();
    @(negedge clk);
    check("rst_m_tvalid", CW'(m_axis_tvalid), CW'(0));
    check("rst_s_tready", CW'(s_axis_tready), CW'(0));
    check("rst_grant", CW'(grant_queue), CW'(0));
    check("rst_pkt_fwd", CW'(pkt_fwd), CW'(0));
    check("rst_pkt_cnt", CW'(pkt_cnt), CW'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    first_tr = -1;
  endtask

  task automatic set_wt(input int a, b, c, d, e);
    wt[0] = a; wt[1] = b; wt[2] = c; wt[3] = d; wt[4] = e;
  endtask

  int exp_order [12] = '{0, 0, 1, 2, 3, 4, 0, 0, 1, 2, 3, 4};
  int n1;
  int n3;

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0;
    s_axis_tdata = '0; s_axis_tstrb = '0; s_axis_tuser = '0;
    s_axis_tvalid = '0; s_axis_tlast = '0;
    m_axis_tready = 1'b0; weight = '0; pkt_cnt_clr = 1'b0;
    rnd_stall = 0; rnd_len = 0; fix_len = 4; rdy_mode = 0;
    set_wt(1, 1, 1, 1, 1);

    // Saturated queues, weights 2,1,1,1,1
    set_wt(2, 1, 1, 1, 1);
    fix_len = 4;
    do_reset();
    for (int q = 0; q < N; q++) left[q] = -1;
    run(60);
    check("first_tready_cycle", CW'(first_tr), CW'(1));
    check("fwd_pulses", CW'(fwd_seen), CW'(11));
    check("start_count", CW'(obs_starts.size() >= 12), CW'(1));
    for (int i = 0; i < 12 && i < obs_starts.size(); i++) begin
      check($sformatf("order_%0d", i),
            CW'(obs_starts[i]), CW'(exp_order[i]));
    end

    // Backpressure on a 6-beat packet from queue 2
    set_wt(1, 1, 1, 1, 1);
    fix_len = 6;
    do_reset();
    rdy_mode = 1;
    left[2] = 1;
    run(30);
    check("bp_beats", CW'(out_beats), CW'(6));
    check("bp_pkts", CW'(obs_starts.size()), CW'(1));
    rdy_mode = 0;

    // Disabled queue 1, only queues 1 and 3 requesting
    set_wt(1, 0, 1, 2, 1);
    rnd_len = 1;
    do_reset();
    left[1] = -1;
    left[3] = -1;
    run(80);
    n1 = 0; n3 = 0;
    foreach (obs_starts[i]) begin
      if (obs_starts[i] == 1) n1++;
      if (obs_starts[i] == 3) n3++;
    end
    check("sparse_q1_pkts", CW'(n1), CW'(0));
    check("sparse_q3_served", CW'(n3 > 10), CW'(1));
    rnd_len = 0;

    // Mid-packet tvalid gap on queue 4 while queue 0 waits
    set_wt(1, 1, 1, 1, 1);
    fix_len = 4;
    do_reset();
    left[4] = 1;
    gap_at[4] = 1;
    gap_len[4] = 3;
    run(3);
    left[0] = 1;
    len[0] = 2;
    run(25);
    check("gap_pkts", CW'(obs_starts.size()), CW'(2));
    if (obs_starts.size() == 2) begin
      check("gap_first", CW'(obs_starts[0]), CW'(4));
      check("gap_second", CW'(obs_starts[1]), CW'(0));
    end

    // Randomized traffic, weights redrawn between windows
    rnd_len = 1;
    rnd_stall = 1;
    rdy_mode = 2;
    do_reset();
    for (int q = 0; q < N; q++) left[q] = -1;
    for (int k = 0; k < 6; k++) begin
      for (int q = 0; q < N; q++) wt[q] = $urandom_range(0, 3);
      run(500);
    end
    rnd_len = 0;
    rnd_stall = 0;
    rdy_mode = 0;

    // Packet counter: 10 packets, then clear on the 11th tlast
    set_wt(0, 1, 0, 0, 0);
    fix_len = 1;
    do_reset();
    left[1] = 10;
    run(40);
`ifdef WRR_PKT_CNT_EN
    check("cnt_q1_10", CW'(pkt_cnt[63:32]), CW'(10));
`else
    check("cnt_q1_10", CW'(pkt_cnt[63:32]), CW'(0));
`endif
    left[1] = 1;
    run(1);
    clr_req = 1;
    run(1);
    clr_req = 0;
    run(2);
    check("cnt_q1_clr", CW'(pkt_cnt[63:32]), CW'(0));
    check("cnt_11_pkts", CW'(seq[1]), CW'(11));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
